multi_timer: RTL

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer_if.sv | 14 +
 rtl/multi_timer.sv | 72 +++++++
 2 files changed

// File: rtl/multi_timer_if.sv
// multi_timer_if: configuration write bus shared by all timer channels
interface multi_timer_if #(
   parameter int WIDTH = 6,
   parameter int CHANNELS = 4
);
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   logic          we;
   logic [CW-1:0] ch;
   logic [1:0]    mode;
   logic [WIDTH-1:0] val;
   logic          load;
   modport master (output we, ch, mode, val, load);
   modport slave (input we, ch, mode, val, load);
endinterface

// File: rtl/multi_timer.sv
// multi_timer: independent up/down timer channels with saturate, wrap, auto-reload and one-shot modes
module multi_timer #(
   parameter int WIDTH = 6,
   parameter int STEP_W = 3,
   parameter int CHANNELS = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   multi_timer_if.slave              cfg,
   input  logic [CHANNELS-1:0]       gate,
   input  logic [CHANNELS-1:0]       way,
   input  logic [STEP_W*CHANNELS-1:0] step,
   input  logic [CHANNELS-1:0]       irq_clr,
   output logic [WIDTH*CHANNELS-1:0] count,
   output logic [CHANNELS-1:0]       tc,
   output logic                      irq
);
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam logic [WIDTH:0] MAX = {1'b0, {WIDTH{1'b1}}};
   logic [CHANNELS-1:0] sticky;
   genvar i;
   for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] cnt, rld, clamp, nxt;
      logic [WIDTH:0]   s, sum, diff;
      logic [1:0]       md;
      logic             done, sel, active, term, ev, tc_r, stk;
      assign sel = cfg.we && cfg.ch == CW'(i);
      // diff[WIDTH] doubles as the borrow flag of the down step
      always_comb begin
         s = (WIDTH+1)'(step[i*STEP_W +: STEP_W]);
         sum = {1'b0, cnt} + s;
         diff = {1'b0, cnt} - s;
         term = way[i] ? (sum >= MAX && cnt != MAX[WIDTH-1:0])
                       : ((diff[WIDTH] || diff == '0) && cnt != '0);
         clamp = way[i] ? (sum >= MAX ? MAX[WIDTH-1:0] : sum[WIDTH-1:0])
                        : (diff[WIDTH] ? '0 : diff[WIDTH-1:0]);
         ev = md == 2'b01 ? (way[i] ? sum[WIDTH] : diff[WIDTH]) : term;
         nxt = md == 2'b01 ? (way[i] ? sum[WIDTH-1:0] : diff[WIDTH-1:0])
                           : (md == 2'b10 && term ? rld : clamp);
         active = gate[i] && !done && !sel;
      end
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            cnt <= '0;
            rld <= '0;
            md <= 2'b00;
            done <= 1'b0;
            tc_r <= 1'b0;
            stk <= 1'b0;
         end else begin
            tc_r <= active && ev;
            stk <= (active && ev) || (stk && !irq_clr[i]);
            if (sel) begin
               md <= cfg.mode;
               rld <= cfg.val;
               done <= 1'b0;
               if (cfg.load) cnt <= cfg.val;
            end else if (active) begin
               cnt <= nxt;
               if (md == 2'b11 && term) done <= 1'b1;
            end
         end
      end
      assign count[i*WIDTH +: WIDTH] = cnt;
      assign tc[i] = tc_r;
      assign sticky[i] = stk;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) irq <= 1'b0;
      else irq <= |sticky;
   end
endmodule
